isq_alc_ctl: RTL



---
 rtl/isq_alc_ctl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/isq_alc_ctl.sv
// isq_alc_ctl: allocation controller in front of the issue queue / TPU rename matrix.
// Accepts one decode group per cycle, drives the ISQ line write enables for the
// current fill group, hands out destination physical registers from a circular
// free list and recycles registers returned by the TPU.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dec_vld         decode group valid
//   dec_dst_vld     per-slot "needs a destination preg"
//   alc_rdy         group can be taken this cycle (independent of dec_vld)
//   alc_pdest_flat  per slot {vld, preg}, slot 0 in the low bits
//   lin_wr_en       ISQ line write enables (one group of INST_PORT lines)
//   counter         current fill group index, to the TPU
//   isq_ful         TPU full indication, blocks allocation
//   rel_preg_flat   per lane {vld, preg} registers returned by the TPU
//   flush, flush_cnt  branch rewind: block allocation and reload counter
//   fl_cnt          free-list occupancy
//   fl_err          sticky free-list overflow (a return was dropped)
module isq_alc_ctl #(
  parameter int ISQ_DEPTH     = 64,
  parameter int INST_PORT     = 4,
  parameter int BITS_IN_COUNT = 4,
  parameter int PREG_BITS     = 6,
  parameter int FL_DEPTH      = 48
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dec_vld,
  input  logic [INST_PORT-1:0]               dec_dst_vld,
  output logic                               alc_rdy,
  output logic [(PREG_BITS+1)*INST_PORT-1:0] alc_pdest_flat,
  output logic [ISQ_DEPTH-1:0]               lin_wr_en,
  output logic [BITS_IN_COUNT-1:0]           counter,
  input  logic                               isq_ful,
  input  logic [(PREG_BITS+1)*INST_PORT-1:0] rel_preg_flat,
  input  logic                               flush,
  input  logic [BITS_IN_COUNT-1:0]           flush_cnt,
  output logic [6:0]                         fl_cnt,
  output logic                               fl_err
);

  localparam int PW        = PREG_BITS + 1;
  localparam int IDX_W     = $clog2(FL_DEPTH);
  localparam int CNT_W     = 7;
  localparam int NEED_W    = $clog2(INST_PORT + 1);
  // Architectural registers occupy the lowest pregs; the free list starts above them.
  localparam int PREG_BASE = (1 << PREG_BITS) - FL_DEPTH;

  logic [PREG_BITS-1:0]                fl_mem_r [FL_DEPTH];
  logic [IDX_W-1:0]                    head_r;
  logic [IDX_W-1:0]                    tail_r;
  logic [CNT_W-1:0]                    fl_cnt_r;
  logic                                fl_err_r;
  logic [BITS_IN_COUNT-1:0]            counter_r;

  logic [NEED_W-1:0]                   need_s;
  logic                                rdy_s;
  logic                                acc_s;
  logic [CNT_W-1:0]                    pops_s;
  logic [PW*INST_PORT-1:0]             pdest_s;
  logic [ISQ_DEPTH-1:0]                lin_s;
  logic [INST_PORT-1:0]                push_en_s;
  logic [INST_PORT-1:0][IDX_W-1:0]     push_addr_s;
  logic [INST_PORT-1:0][PREG_BITS-1:0] push_data_s;
  logic [IDX_W-1:0]                    tail_nxt_s;
  logic [CNT_W-1:0]                    cnt_nxt_s;
  logic                                overflow_s;

  function automatic logic [NEED_W-1:0] popcount(input logic [INST_PORT-1:0] v);
    logic [NEED_W-1:0] n;
    n = {NEED_W{1'b0}};
    for (int i = 0; i < INST_PORT; i++) begin
      n = n + NEED_W'(v[i]);
    end
    return n;
  endfunction

  // Advance a free-list pointer by inc, wrapping at FL_DEPTH (not a power of two).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] idx,
                                                input logic [NEED_W-1:0] inc);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + (IDX_W+1)'(inc);
    if (sum >= (IDX_W+1)'(FL_DEPTH)) begin
      sum = sum - (IDX_W+1)'(FL_DEPTH);
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Demand and acceptance; only registered free-list state feeds these.
  always_comb begin
    need_s = popcount(dec_dst_vld);
    rdy_s  = ~isq_ful & ~flush & (fl_cnt_r >= CNT_W'(need_s));
    acc_s  = dec_vld & rdy_s;
    pops_s = acc_s ? CNT_W'(need_s) : {CNT_W{1'b0}};
    lin_s  = acc_s ? ({{(ISQ_DEPTH-INST_PORT){1'b0}}, {INST_PORT{1'b1}}} << (INST_PORT * counter_r))
                   : {ISQ_DEPTH{1'b0}};
  end

  // Hand out consecutive free-list entries to requesting slots in ascending slot order.
  always_comb begin
    logic [IDX_W-1:0] rd_idx;
    rd_idx  = head_r;
    pdest_s = {(PW*INST_PORT){1'b0}};
    for (int i = 0; i < INST_PORT; i++) begin
      if (acc_s && dec_dst_vld[i]) begin
        pdest_s[i*PW +: PW] = {1'b1, fl_mem_r[rd_idx]};
        rd_idx = wrap_add(rd_idx, NEED_W'(1));
      end else begin
        pdest_s[i*PW +: PW] = {PW{1'b0}};
      end
    end
  end

  // Place returned registers at the tail; occupancy starts after this cycle's pops,
  // so a return that would exceed capacity is dropped and flagged.
  always_comb begin
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] occ;
    wr_idx      = tail_r;
    occ         = fl_cnt_r - pops_s;
    overflow_s  = 1'b0;
    push_en_s   = {INST_PORT{1'b0}};
    push_addr_s = '0;
    push_data_s = '0;
    for (int i = 0; i < INST_PORT; i++) begin
      push_data_s[i] = rel_preg_flat[i*PW +: PREG_BITS];
      if (rel_preg_flat[i*PW + PREG_BITS]) begin
        if (occ < CNT_W'(FL_DEPTH)) begin
          push_en_s[i]   = 1'b1;
          push_addr_s[i] = wr_idx;
          wr_idx         = wrap_add(wr_idx, NEED_W'(1));
          occ            = occ + CNT_W'(1);
        end else begin
          overflow_s = 1'b1;
        end
      end else begin
        push_en_s[i] = 1'b0;
      end
    end
    tail_nxt_s = wr_idx;
    cnt_nxt_s  = occ;
  end

  // State update: fill counter, free-list pointers, occupancy, sticky error and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_r <= {BITS_IN_COUNT{1'b0}};
      head_r    <= {IDX_W{1'b0}};
      tail_r    <= {IDX_W{1'b0}};
      fl_cnt_r  <= CNT_W'(FL_DEPTH);
      fl_err_r  <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_mem_r[i] <= PREG_BITS'(PREG_BASE + i);
      end
    end else begin
      if (flush) begin
        counter_r <= flush_cnt;
      end else if (acc_s) begin
        counter_r <= counter_r + BITS_IN_COUNT'(1);
      end
      if (acc_s) begin
        head_r <= wrap_add(head_r, need_s);
      end
      tail_r   <= tail_nxt_s;
      fl_cnt_r <= cnt_nxt_s;
      if (overflow_s) begin
        fl_err_r <= 1'b1;
      end
      for (int i = 0; i < INST_PORT; i++) begin
        if (push_en_s[i]) begin
          fl_mem_r[push_addr_s[i]] <= push_data_s[i];
        end
      end
    end
  end

  assign alc_rdy        = rdy_s;
  assign alc_pdest_flat = pdest_s;
  assign lin_wr_en      = lin_s;
  assign counter        = counter_r;
  assign fl_cnt         = fl_cnt_r;
  assign fl_err         = fl_err_r;

endmodule
